// File: rtl/lfsr_tercnt_monitor.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_tercnt_monitor
// Description : Watches a dynamic-count-to LFSR counter. Measures the cycle
//               distance between terminal-count events, counts the events and
//               raises sticky flags for tercnt/compare mismatch, a frozen
//               counter and a saturated period counter.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_tercnt_monitor #(
  parameter int width     = 4,
  parameter int PW        = 16,
  parameter int CW        = 8,
  parameter int STUCK_LIM = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cen,
  input  logic             load,
  input  logic [width-1:0] count_to,
  input  logic [width-1:0] count,
  input  logic             tercnt,
  input  logic             clr_err,
  output logic [PW-1:0]    period,
  output logic             period_valid,
  output logic             period_ovf,
  output logic [CW-1:0]    wrap_count,
  output logic             err_match,
  output logic             err_stuck
);

  localparam int SW = $clog2(STUCK_LIM + 1);
  localparam logic [PW-1:0] C_CYC_MAX   = '1;
  localparam logic [CW-1:0] C_WRAP_MAX  = '1;
  localparam logic [SW-1:0] C_STUCK_MAX = SW'(STUCK_LIM);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [PW-1:0]     cyc_cnt, cyc_next;
  logic [PW-1:0]     period_next;
  logic              valid_next;
  logic [CW-1:0]     wrap_next, wrap_inc;
  logic              ovf_set;
  logic [width-1:0]  count_q;
  logic              en_q;
  logic [SW-1:0]     stuck_cnt, stuck_inc, stuck_next;
  logic              stuck_hit, stuck_set, match_bad, ev;

  // A terminal-count event only counts when the counter actually advances.
  assign ev       = tercnt & cen & ~load;
  assign wrap_inc = (wrap_count == C_WRAP_MAX) ? wrap_count : wrap_count + CW'(1);

  // Mismatch between the counter's own tercnt and the compare it should reflect.
  assign match_bad = ~load & (tercnt != (count == count_to));

  // Frozen-count detection: compare against last cycle's count when it was enabled.
  assign stuck_hit  = en_q & (count == count_q);
  assign stuck_inc  = !stuck_hit ? '0 :
                      (stuck_cnt == C_STUCK_MAX) ? stuck_cnt : stuck_cnt + SW'(1);
  assign stuck_set  = stuck_hit & (stuck_inc == C_STUCK_MAX);
  assign stuck_next = clr_err ? '0 : stuck_inc;

  // Next-state and next-datapath values; load overrides any same-cycle event.
  always_comb begin
    state_next  = state;
    cyc_next    = cyc_cnt;
    period_next = period;
    valid_next  = 1'b0;
    wrap_next   = wrap_count;
    ovf_set     = 1'b0;
    if (load) begin
      state_next = IDLE;
      cyc_next   = '0;
      wrap_next  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (ev) begin
            state_next = ARMED;
            cyc_next   = PW'(1);
            wrap_next  = wrap_inc;
          end
        end
        ARMED: begin
          if (ev) begin
            period_next = cyc_cnt;
            valid_next  = 1'b1;
            cyc_next    = PW'(1);
            wrap_next   = wrap_inc;
          end else begin
            cyc_next = (cyc_cnt == C_CYC_MAX) ? cyc_cnt : cyc_cnt + PW'(1);
            ovf_set  = (cyc_next == C_CYC_MAX);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Period measurement, event counting and sticky flags (set beats clear).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_cnt      <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      period_ovf   <= 1'b0;
      wrap_count   <= '0;
      err_match    <= 1'b0;
      err_stuck    <= 1'b0;
    end else begin
      cyc_cnt      <= cyc_next;
      period       <= period_next;
      period_valid <= valid_next;
      period_ovf   <= ovf_set   | (period_ovf & ~clr_err);
      wrap_count   <= wrap_next;
      err_match    <= match_bad | (err_match & ~clr_err);
      err_stuck    <= stuck_set | (err_stuck & ~clr_err);
    end
  end

  // History for the frozen-count check.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      en_q      <= 1'b0;
      stuck_cnt <= '0;
    end else begin
      count_q   <= count;
      en_q      <= cen & ~load;
      stuck_cnt <= stuck_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lfsr_tercnt_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_tercnt_monitor
// Description : Directed self-checking bench for lfsr_tercnt_monitor. Drives
//               the counter taps directly; a second instance uses PW=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_tercnt_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, cen, load, tercnt, clr_err;
  logic [3:0] count_to, count;
  logic [3:0] filler;

  logic [15:0] period;
  logic        period_valid, period_ovf, err_match, err_stuck;
  logic [7:0]  wrap_count;

  logic [3:0]  period4;
  logic        period_valid4, period_ovf4, err_match4, err_stuck4;
  logic [7:0]  wrap_count4;

  int total = 0;
  int bad   = 0;

  lfsr_tercnt_monitor dut (
    .clk(clk), .reset(reset), .cen(cen), .load(load), .count_to(count_to),
    .count(count), .tercnt(tercnt), .clr_err(clr_err), .period(period),
    .period_valid(period_valid), .period_ovf(period_ovf), .wrap_count(wrap_count),
    .err_match(err_match), .err_stuck(err_stuck)
  );

  lfsr_tercnt_monitor #(.PW(4)) dut4 (
    .clk(clk), .reset(reset), .cen(cen), .load(load), .count_to(count_to),
    .count(count), .tercnt(tercnt), .clr_err(clr_err), .period(period4),
    .period_valid(period_valid4), .period_ovf(period_ovf4), .wrap_count(wrap_count4),
    .err_match(err_match4), .err_stuck(err_stuck4)
  );

  // One clock with consistent counter taps: either a terminal event or a
  // non-matching count that alternates so the counter never looks frozen.
  task automatic step(input logic ev);
    tercnt = ev;
    count  = ev ? count_to : filler;
    filler = (filler == 4'd1) ? 4'd2 : 4'd1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; cen = 1'b1; load = 1'b0; clr_err = 1'b0;
    count_to = 4'b1010; count = 4'd1; tercnt = 1'b0; filler = 4'd1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (period !== 16'd0)    begin bad++; $display("FAIL rst_period got=%0d want=0", period); end
    total++; if (wrap_count !== 8'd0) begin bad++; $display("FAIL rst_wrap got=%0d want=0", wrap_count); end
    reset = 1'b0;
    step(1'b1);
    repeat (4) step(1'b0);
    step(1'b1);
    // inconsistent taps for one cycle, cen low so it is not an event
    cen = 1'b0; tercnt = 1'b1; count = 4'd3;
    @(posedge clk); #1;
    cen = 1'b1;
    repeat (5) step(1'b0);   // cyc_cnt now 7
    total++; if (period !== 16'd5)    begin bad++; $display("FAIL pre_rst_period got=%0d want=5", period); end
    total++; if (wrap_count !== 8'd2) begin bad++; $display("FAIL pre_rst_wrap got=%0d want=2", wrap_count); end
    total++; if (err_match !== 1'b1)  begin bad++; $display("FAIL pre_rst_err_match got=%0b want=1", err_match); end
    #2 reset = 1'b1;
    #1;
    total++; if (period !== 16'd0)    begin bad++; $display("FAIL async_rst_period got=%0d want=0", period); end
    total++; if (wrap_count !== 8'd0) begin bad++; $display("FAIL async_rst_wrap got=%0d want=0", wrap_count); end
    total++; if (err_match !== 1'b0)  begin bad++; $display("FAIL async_rst_err_match got=%0b want=0", err_match); end
    total++; if ({period_valid, period_ovf, err_stuck} !== 3'b000) begin
      bad++; $display("FAIL async_rst_flags got=%b want=000", {period_valid, period_ovf, err_stuck});
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_period;
    repeat (3) step(1'b0);
    step(1'b1);
    total++; if (period_valid !== 1'b0) begin bad++; $display("FAIL first_ev_valid got=%0b want=0", period_valid); end
    total++; if (wrap_count !== 8'd1)   begin bad++; $display("FAIL first_ev_wrap got=%0d want=1", wrap_count); end
    repeat (14) step(1'b0);
    step(1'b1);
    total++; if (period !== 16'd15)     begin bad++; $display("FAIL period15 got=%0d want=15", period); end
    total++; if (period_valid !== 1'b1) begin bad++; $display("FAIL period15_valid got=%0b want=1", period_valid); end
    total++; if (wrap_count !== 8'd2)   begin bad++; $display("FAIL period15_wrap got=%0d want=2", wrap_count); end
    step(1'b0);
    total++; if (period_valid !== 1'b0) begin bad++; $display("FAIL valid_one_cycle got=%0b want=0", period_valid); end
    total++; if (period !== 16'd15)     begin bad++; $display("FAIL period_hold got=%0d want=15", period); end
  endtask

  task automatic test_load;
    repeat (3) step(1'b0);
    load = 1'b1;
    step(1'b1);
    load = 1'b0;
    total++; if (wrap_count !== 8'd0)   begin bad++; $display("FAIL load_wrap got=%0d want=0", wrap_count); end
    total++; if (period_valid !== 1'b0) begin bad++; $display("FAIL load_valid got=%0b want=0", period_valid); end
    total++; if (period !== 16'd15)     begin bad++; $display("FAIL load_period got=%0d want=15", period); end
    step(1'b0);
    step(1'b1);
    total++; if (period_valid !== 1'b0) begin bad++; $display("FAIL after_load_valid got=%0b want=0", period_valid); end
    total++; if (wrap_count !== 8'd1)   begin bad++; $display("FAIL after_load_wrap got=%0d want=1", wrap_count); end
    repeat (5) step(1'b0);
    step(1'b1);
    total++; if (period !== 16'd6)      begin bad++; $display("FAIL period6 got=%0d want=6", period); end
    total++; if (period_valid !== 1'b1) begin bad++; $display("FAIL period6_valid got=%0b want=1", period_valid); end
    total++; if (wrap_count !== 8'd2)   begin bad++; $display("FAIL period6_wrap got=%0d want=2", wrap_count); end
  endtask

  task automatic test_err_match;
    total++; if (err_match !== 1'b0) begin bad++; $display("FAIL match_idle got=%0b want=0", err_match); end
    cen = 1'b0; count = 4'b1010; tercnt = 1'b0;
    @(posedge clk); #1;
    cen = 1'b1;
    total++; if (err_match !== 1'b1) begin bad++; $display("FAIL match_set got=%0b want=1", err_match); end
    repeat (3) step(1'b0);
    total++; if (err_match !== 1'b1) begin bad++; $display("FAIL match_sticky got=%0b want=1", err_match); end
    clr_err = 1'b1; cen = 1'b0; count = 4'b1010; tercnt = 1'b0;
    @(posedge clk); #1;
    cen = 1'b1;
    total++; if (err_match !== 1'b1) begin bad++; $display("FAIL match_set_wins got=%0b want=1", err_match); end
    step(1'b0);
    clr_err = 1'b0;
    total++; if (err_match !== 1'b0) begin bad++; $display("FAIL match_clr got=%0b want=0", err_match); end
  endtask

  task automatic test_stuck;
    total++; if (err_stuck !== 1'b0) begin bad++; $display("FAIL stuck_idle got=%0b want=0", err_stuck); end
    step(1'b0);
    count = 4'b0011; tercnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (err_stuck !== 1'b0) begin bad++; $display("FAIL stuck_early got=%0b want=0", err_stuck); end
    @(posedge clk); #1;
    total++; if (err_stuck !== 1'b1) begin bad++; $display("FAIL stuck_set got=%0b want=1", err_stuck); end
    clr_err = 1'b1;
    step(1'b0);
    clr_err = 1'b0;
    total++; if (err_stuck !== 1'b0) begin bad++; $display("FAIL stuck_clr got=%0b want=0", err_stuck); end
    cen = 1'b0; count = 4'b0011;
    repeat (6) @(posedge clk);
    #1;
    cen = 1'b1;
    total++; if (err_stuck !== 1'b0) begin bad++; $display("FAIL stuck_cen_low got=%0b want=0", err_stuck); end
  endtask

  task automatic test_saturation;
    clr_err = 1'b1; load = 1'b1;
    step(1'b0);
    clr_err = 1'b0; load = 1'b0;
    total++; if (period_ovf4 !== 1'b0) begin bad++; $display("FAIL ovf4_clear got=%0b want=0", period_ovf4); end
    step(1'b1);
    repeat (19) step(1'b0);
    step(1'b1);
    total++; if (period4 !== 4'd15)    begin bad++; $display("FAIL period4_sat got=%0d want=15", period4); end
    total++; if (period_ovf4 !== 1'b1) begin bad++; $display("FAIL ovf4_set got=%0b want=1", period_ovf4); end
    total++; if (period !== 16'd20)    begin bad++; $display("FAIL period20 got=%0d want=20", period); end
    total++; if (period_ovf !== 1'b0)  begin bad++; $display("FAIL ovf16 got=%0b want=0", period_ovf); end
    load = 1'b1;
    step(1'b0);
    load = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      step(1'b1);
      step(1'b0);
      if (i == 254) begin
        total++; if (wrap_count !== 8'd254) begin bad++; $display("FAIL wrap254 got=%0d want=254", wrap_count); end
      end
    end
    total++; if (wrap_count !== 8'd255)  begin bad++; $display("FAIL wrap_sat got=%0d want=255", wrap_count); end
    total++; if (wrap_count4 !== 8'd255) begin bad++; $display("FAIL wrap4_sat got=%0d want=255", wrap_count4); end
  endtask

  initial begin
    test_reset();
    test_period();
    test_load();
    test_err_match();
    test_stuck();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
